// File: rtl/proto_pkg.sv
// Shared ProtoCore datapath sizing, reused by the register file, decode and ALU.
//   DATA_W   : datapath / register width in bits
//   ADDR_W   : register address width
//   NUM_REGS : number of general-purpose registers (2**ADDR_W)
package proto_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned NUM_REGS = 16;

endpackage : proto_pkg

// File: rtl/regfile_if.sv
// Register-file access bus: two read ports and one write port.
//   ra, rb  : read port A/B addresses        (master -> slave)
//   wa, wd  : write address / write data     (master -> slave)
//   we      : write enable, sampled at clk   (master -> slave)
//   read_a  : contents of register ra        (slave -> master)
//   read_b  : contents of register rb        (slave -> master)
// The decode/control unit is the master; the register file is the slave.
interface regfile_if #(
    parameter int unsigned DATA_W = proto_pkg::DATA_W,
    parameter int unsigned ADDR_W = proto_pkg::ADDR_W
);

    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rb;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              we;
    logic [DATA_W-1:0] read_a;
    logic [DATA_W-1:0] read_b;

    modport master (
        output ra, rb, wa, wd, we,
        input  read_a, read_b
    );

    modport slave (
        input  ra, rb, wa, wd, we,
        output read_a, read_b
    );

endinterface : regfile_if

// File: rtl/regfile.sv
// ProtoCore general-purpose register file: 2**ADDR_W registers of DATA_W bits,
// two independent combinational read ports and one synchronous write port.
//   clk  : system clock, state changes on the rising edge
//   rst  : synchronous active-high reset, clears every register to zero
//   bus  : regfile_if slave modport (ra, rb, wa, wd, we in; read_a, read_b out)
// Reads have no write-through bypass: a register being written shows its old
// value until the edge commits the new one.
module regfile #(
    parameter int unsigned DATA_W = proto_pkg::DATA_W,
    parameter int unsigned ADDR_W = proto_pkg::ADDR_W
) (
    input  logic      clk,
    input  logic      rst,
    regfile_if.slave  bus
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Reset and write port; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.we) begin
            r_regs[bus.wa] <= bus.wd;
        end
    end

    // Combinational read muxes, fully independent of each other.
    assign bus.read_a = r_regs[bus.ra];
    assign bus.read_b = r_regs[bus.rb];

endmodule : regfile

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed cases followed by random traffic,
// with expectations queued by the driver and compared by a separate monitor.
module tb_regfile;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned NR = 16;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
    } exp_t;

    logic clk;
    logic rst;

    regfile_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain array of register values.
    logic [DW-1:0] mdl [NR];
    exp_t          exp_q [$];
    int            checks;
    int            errors;
    bit            stim_done;

    // Drive one cycle: apply inputs, queue what the read ports must show
    // before the edge, then let the edge happen and update the model.
    task automatic step(input logic r, input logic w, input logic [AW-1:0] a_w,
                        input logic [DW-1:0] d, input logic [AW-1:0] a_r,
                        input logic [AW-1:0] b_r, input bit chk);
        exp_t e;
        rst    = r;
        bus.we = w;
        bus.wa = a_w;
        bus.wd = d;
        bus.ra = a_r;
        bus.rb = b_r;
        if (chk) begin
            e.a  = mdl[a_r];
            e.b  = mdl[b_r];
            e.ra = a_r;
            e.rb = b_r;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < int'(NR); i++) mdl[i] = '0;
        end else if (w) begin
            mdl[a_w] = d;
        end
    endtask

    // Monitor: the read ports are valid mid-cycle; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.read_a !== e.a || bus.read_b !== e.b) begin
                errors++;
                $display("FAIL read_ports t=%0t ra=%0d rb=%0d: got a=%02h b=%02h, expected a=%02h b=%02h",
                         $time, e.ra, e.rb, bus.read_a, bus.read_b, e.a, e.b);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: stimulus_done=%0b, expected 1", stim_done);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [AW-1:0] a_w, a_r, b_r;
        logic [DW-1:0] d;
        logic          r, w;
        checks    = 0;
        errors    = 0;
        stim_done = 1'b0;
        for (int i = 0; i < int'(NR); i++) mdl[i] = '0;
        rst    = 1'b1;
        bus.we = 1'b0;
        bus.wa = '0;
        bus.wd = '0;
        bus.ra = '0;
        bus.rb = '0;
        @(posedge clk);
        #1;

        // Initial reset, contents unknown before it.
        step(1'b1, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd15, 1'b1);

        // Reset clears a written register and drops a concurrent write.
        step(1'b0, 1'b1, 4'd7, 8'h5A, 4'd7, 4'd2, 1'b1);
        step(1'b0, 1'b0, 4'd0, 8'h00, 4'd7, 4'd2, 1'b1);
        step(1'b1, 1'b1, 4'd2, 8'h77, 4'd7, 4'd2, 1'b0);
        step(1'b0, 1'b0, 4'd2, 8'h77, 4'd7, 4'd2, 1'b1);

        // Fill r_i = i*0x11 back to back, then sweep both ports.
        for (int i = 0; i < int'(NR); i++)
            step(1'b0, 1'b1, AW'(i), DW'(i * 'h11), 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < int'(NR); i++)
            step(1'b0, 1'b0, 4'd0, 8'h00, AW'(i), AW'(15 - i), 1'b1);

        // Overwrite r3, then confirm only r3 changed.
        step(1'b0, 1'b1, 4'd3, 8'hAA, 4'd3, 4'd3, 1'b1);
        step(1'b0, 1'b0, 4'd0, 8'h00, 4'd3, 4'd3, 1'b1);
        for (int i = 0; i < int'(NR); i++)
            step(1'b0, 1'b0, 4'd0, 8'h00, AW'(i), AW'(i ^ 1), 1'b1);

        // we=0 must not write.
        step(1'b0, 1'b0, 4'd5, 8'h11, 4'd5, 4'd5, 1'b1);
        step(1'b0, 1'b0, 4'd5, 8'h11, 4'd5, 4'd5, 1'b1);

        // No bypass: old value before the edge, new value after.
        step(1'b0, 1'b1, 4'd9, 8'h3C, 4'd9, 4'd9, 1'b1);
        step(1'b0, 1'b0, 4'd0, 8'h00, 4'd9, 4'd9, 1'b1);

        // r0 is writable; same-address reads on both ports.
        step(1'b0, 1'b1, 4'd0, 8'hE1, 4'd0, 4'd0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b1);

        // Back-to-back writes to the same address: last wins.
        step(1'b0, 1'b1, 4'd6, 8'h12, 4'd6, 4'd6, 1'b1);
        step(1'b0, 1'b1, 4'd6, 8'h34, 4'd6, 4'd6, 1'b1);
        step(1'b0, 1'b0, 4'd0, 8'h00, 4'd6, 4'd6, 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            r   = ($urandom_range(0, 39) == 0);
            w   = ($urandom_range(0, 2) != 0);
            a_w = AW'($urandom);
            d   = DW'($urandom);
            a_r = ($urandom_range(0, 3) == 0) ? a_w : AW'($urandom);
            b_r = ($urandom_range(0, 3) == 0) ? a_r : AW'($urandom);
            step(r, w, a_w, d, a_r, b_r, 1'b1);
        end

        step(1'b0, 1'b0, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        stim_done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile
